// File: rtl/display_arbiter.sv
// Arbitrates the 4-digit display between a live background value and two
// overlay sources that each take the display for HOLD_CYCLES clocks per request.
module display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] base_val,
  input  logic [1:0]  req,
  input  logic [15:0] ov0_val,
  input  logic [15:0] ov1_val,
  output logic [1:0]  ack,
  output logic        busy,
  output logic [1:0]  active_src,
  output logic [3:0]  num3,
  output logic [3:0]  num2,
  output logic [3:0]  num1,
  output logic [3:0]  num0
);

  localparam int unsigned TW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHOW0 = 2'b01,
    SHOW1 = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   disp_q, disp_d;
  logic [1:0]    ack_q, ack_d;
  logic          busy_q, busy_d;
  logic [1:0]    active_q, active_d;
  logic [1:0]    req_q, req_d;
  logic [1:0]    pend_q, pend_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          last_q, last_d;

  logic [1:0] evt;
  logic       gnt_en;
  logic       gnt_src;
  logic       cur;
  logic       oth;

  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    ack_d   = '0;
    pend_d  = pend_q;
    timer_d = timer_q;
    last_d  = last_q;
    req_d   = req;
    evt     = req & ~req_q;
    gnt_en  = 1'b0;
    gnt_src = 1'b0;
    cur     = (state_q == SHOW1);
    oth     = ~cur;

    if (state_q == IDLE) begin
      disp_d  = base_val;
      timer_d = '0;
      if (evt == 2'b11) begin
        // Round robin: favour the source not granted last; the loser waits.
        gnt_en         = 1'b1;
        gnt_src        = ~last_q;
        pend_d[last_q] = 1'b1;
      end else if (evt[0]) begin
        gnt_en  = 1'b1;
        gnt_src = 1'b0;
      end else if (evt[1]) begin
        gnt_en  = 1'b1;
        gnt_src = 1'b1;
      end
    end else begin
      timer_d = timer_q + 1'b1;
      if (evt[oth]) pend_d[oth] = 1'b1;
      if (evt[cur]) begin
        timer_d  = '0;
        disp_d   = cur ? ov1_val : ov0_val;
        ack_d[cur] = 1'b1;
      end else if (timer_q == TLAST) begin
        if (pend_q[oth] || evt[oth]) begin
          gnt_en  = 1'b1;
          gnt_src = oth;
        end else begin
          state_d = IDLE;
          disp_d  = base_val;
          timer_d = '0;
        end
      end
    end

    if (gnt_en) begin
      state_d         = gnt_src ? SHOW1 : SHOW0;
      disp_d          = gnt_src ? ov1_val : ov0_val;
      ack_d           = gnt_src ? 2'b10 : 2'b01;
      pend_d[gnt_src] = 1'b0;
      timer_d         = '0;
      last_d          = gnt_src;
    end

    busy_d   = (state_d != IDLE);
    active_d = state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      disp_q   <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
      active_q <= '0;
      req_q    <= '0;
      pend_q   <= '0;
      timer_q  <= '0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      disp_q   <= disp_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      active_q <= active_d;
      req_q    <= req_d;
      pend_q   <= pend_d;
      timer_q  <= timer_d;
      last_q   <= last_d;
    end
  end

  assign ack        = ack_q;
  assign busy       = busy_q;
  assign active_src = active_q;
  assign num3       = disp_q[15:12];
  assign num2       = disp_q[11:8];
  assign num1       = disp_q[7:4];
  assign num0       = disp_q[3:0];

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with an 8-cycle overlay hold.
module tb_display_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] base_val;
  logic [1:0]  req;
  logic [15:0] ov0_val;
  logic [15:0] ov1_val;
  logic [1:0]  ack;
  logic        busy;
  logic [1:0]  active_src;
  logic [3:0]  num3, num2, num1, num0;
  logic [15:0] num;

  int tests;
  int fails;

  display_arbiter #(.HOLD_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .base_val(base_val), .req(req),
    .ov0_val(ov0_val), .ov1_val(ov1_val), .ack(ack), .busy(busy),
    .active_src(active_src), .num3(num3), .num2(num2), .num1(num1), .num0(num0)
  );

  assign num = {num3, num2, num1, num0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; base_val = 16'h1234; req = 2'b00;
    ov0_val = 16'h0; ov1_val = 16'h0;
    tick(); tick();
    tests++;
    if (num !== 16'h0000 || busy !== 1'b0 || ack !== 2'b00 || active_src !== 2'b00) begin
      fails++;
      $display("FAIL reset_state: num=%h busy=%b ack=%b src=%b, want 0000 0 00 00", num, busy, ack, active_src);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (num !== 16'h1234 || busy !== 1'b0 || active_src !== 2'b00) begin
      fails++;
      $display("FAIL reset_release: num=%h busy=%b src=%b, want 1234 0 00", num, busy, active_src);
    end
  endtask

  task automatic test_single();
    int disp_cnt, ack_cnt, bad_snap;
    req = 2'b01; ov0_val = 16'hABCD;
    tick();
    tests++;
    if (ack !== 2'b01 || num !== 16'hABCD || busy !== 1'b1 || active_src !== 2'b01) begin
      fails++;
      $display("FAIL single_grant: ack=%b num=%h busy=%b src=%b, want 01 abcd 1 01", ack, num, busy, active_src);
    end
    disp_cnt = 1; ack_cnt = 1; bad_snap = 0;
    ov0_val = 16'h5555;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (busy) disp_cnt++;
      if (ack !== 2'b00) ack_cnt++;
      if (busy && num !== 16'hABCD) bad_snap++;
    end
    tests++;
    if (disp_cnt !== 8) begin
      fails++;
      $display("FAIL single_hold: got %0d cycles, want 8", disp_cnt);
    end
    tests++;
    if (ack_cnt !== 1) begin
      fails++;
      $display("FAIL single_ack_once: got %0d acks, want 1", ack_cnt);
    end
    tests++;
    if (bad_snap !== 0) begin
      fails++;
      $display("FAIL single_snapshot: %0d cycles off snapshot, want 0", bad_snap);
    end
    tests++;
    if (num !== 16'h1234 || busy !== 1'b0 || active_src !== 2'b00) begin
      fails++;
      $display("FAIL single_revert: num=%h busy=%b src=%b, want 1234 0 00", num, busy, active_src);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_simultaneous();
    int bad;
    do_reset();
    ov0_val = 16'hABCD; ov1_val = 16'h9876;
    req = 2'b11;
    tick();
    tests++;
    if (ack !== 2'b01 || active_src !== 2'b01 || num !== 16'hABCD) begin
      fails++;
      $display("FAIL simul_first: ack=%b src=%b num=%h, want 01 01 abcd", ack, active_src, num);
    end
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (active_src !== 2'b01 || ack !== 2'b00) bad++;
    end
    tick();
    tests++;
    if (bad !== 0 || ack !== 2'b10 || active_src !== 2'b10 || busy !== 1'b1 || num !== 16'h9876) begin
      fails++;
      $display("FAIL simul_second: bad=%0d ack=%b src=%b busy=%b num=%h, want 0 10 10 1 9876",
               bad, ack, active_src, busy, num);
    end
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (active_src !== 2'b10 || num !== 16'h9876) bad++;
    end
    tick();
    tests++;
    if (bad !== 0 || active_src !== 2'b00 || num !== 16'h1234) begin
      fails++;
      $display("FAIL simul_end: bad=%0d src=%b num=%h, want 0 00 1234", bad, active_src, num);
    end
    req = 2'b00;
    tick();
    req = 2'b11;
    tick();
    tests++;
    if (ack !== 2'b01 || active_src !== 2'b01) begin
      fails++;
      $display("FAIL simul_rr: ack=%b src=%b, want 01 01", ack, active_src);
    end
  endtask

  task automatic test_retrigger();
    int busy_cnt;
    do_reset();
    ov0_val = 16'h1111; req = 2'b01;
    tick();
    req = 2'b00;
    for (int i = 0; i < 4; i++) tick();
    req = 2'b01; ov0_val = 16'h2222;
    tick();
    tests++;
    if (ack !== 2'b01 || num !== 16'h2222 || busy !== 1'b1) begin
      fails++;
      $display("FAIL retrig_ack: ack=%b num=%h busy=%b, want 01 2222 1", ack, num, busy);
    end
    req = 2'b00;
    busy_cnt = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy) busy_cnt++;
    end
    tests++;
    if (busy_cnt !== 8 || num !== 16'h1234) begin
      fails++;
      $display("FAIL retrig_hold: cycles=%0d num=%h, want 8 1234", busy_cnt, num);
    end
  endtask

  task automatic test_expiry_collision();
    do_reset();
    ov0_val = 16'hAAAA; ov1_val = 16'hBBBB; req = 2'b01;
    tick();
    req = 2'b00;
    for (int i = 0; i < 7; i++) tick();
    tests++;
    if (active_src !== 2'b01) begin
      fails++;
      $display("FAIL expiry_pre: src=%b, want 01", active_src);
    end
    req = 2'b10;
    tick();
    tests++;
    if (ack !== 2'b10 || active_src !== 2'b10 || num !== 16'hBBBB || busy !== 1'b1) begin
      fails++;
      $display("FAIL expiry_handoff: ack=%b src=%b num=%h busy=%b, want 10 10 bbbb 1",
               ack, active_src, num, busy);
    end
    req = 2'b00;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    ov0_val = 16'hCCCC; ov1_val = 16'hDDDD; req = 2'b11;
    tick();
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0 || num !== 16'h0000 || active_src !== 2'b00) begin
      fails++;
      $display("FAIL midreset_state: busy=%b num=%h src=%b, want 0 0000 00", busy, num, active_src);
    end
    req = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if (busy !== 1'b0 || num !== 16'h1234 || active_src !== 2'b00 || ack !== 2'b00) begin
      fails++;
      $display("FAIL midreset_release: busy=%b num=%h src=%b ack=%b, want 0 1234 00 00",
               busy, num, active_src, ack);
    end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy !== 1'b0 || ack !== 2'b00) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL midreset_nopend: %0d busy/ack cycles, want 0", bad);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_simultaneous();
    test_retrigger();
    test_expiry_collision();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
